// File: rtl/pc_unit_if.sv
// Fetch-stage PC unit bus: I-cache/hazard/redirect/RAS inputs and fetch-address outputs.
// master drives the control inputs, slave is the PC unit itself.
interface pc_unit_if #(
    parameter int unsigned PC_W = 32
);
    logic            ihit;
    logic            stall;
    logic            halt;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] current_pc;
    logic [PC_W-1:0] pc_plus_step;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            halted;
    logic            redirect_pending;

    modport master (
        output ihit, stall, halt, redirect, redirect_pc, ras_push, ras_pop,
        input  current_pc, pc_plus_step, ras_top, ras_empty, halted, redirect_pending
    );

    modport slave (
        input  ihit, stall, halt, redirect, redirect_pc, ras_push, ras_pop,
        output current_pc, pc_plus_step, ras_top, ras_empty, halted, redirect_pending
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: sequential stepping, buffered redirects,
// sticky halt and a small circular return-address stack.
module pc_unit #(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int unsigned     STEP      = 4,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input logic         CLK,
    input logic         nRST,
    pc_unit_if.slave    bus
);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            pend_q, pend_d;
    logic            halted_q, halted_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0] ras_q [RAS_DEPTH];

    logic            hold, seq_go, redir_go;
    logic            ras_we;
    logic [PtrW-1:0] ras_widx;
    logic [PtrW-1:0] top_idx;
    logic [PC_W-1:0] pc_plus_step;

    assign pc_plus_step = pc_q + PC_W'(STEP);
    assign hold         = bus.halt | halted_q;
    assign seq_go       = bus.ihit & ~bus.stall & ~hold;
    // stall only blocks sequential fetch; a resolved redirect still goes through
    assign redir_go     = bus.ihit & ~hold;
    assign top_idx      = ptr_q - PtrW'(1);

    always_comb begin
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        halted_d  = halted_q | bus.halt;
        if (bus.redirect) begin
            if (redir_go) begin
                pc_d   = bus.redirect_pc;
                pend_d = 1'b0;
            end else begin
                pend_pc_d = bus.redirect_pc;
                pend_d    = 1'b1;
            end
        end else if (pend_q && redir_go) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
        end else if (seq_go) begin
            pc_d = pc_plus_step;
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ras_we   = 1'b0;
        ras_widx = ptr_q;
        if (seq_go) begin
            if (bus.ras_push && bus.ras_pop && cnt_q != '0) begin
                // call-and-return in one fetch: replace the top in place
                ras_we   = 1'b1;
                ras_widx = top_idx;
            end else if (bus.ras_push) begin
                ras_we = 1'b1;
                ptr_d  = ptr_q + PtrW'(1);
                if (cnt_q != CntW'(RAS_DEPTH)) cnt_d = cnt_q + CntW'(1);
            end else if (bus.ras_pop && cnt_q != '0) begin
                ptr_d = top_idx;
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            pend_q    <= 1'b0;
            halted_q  <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pend_q    <= pend_d;
            halted_q  <= halted_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // entries are only ever read when count says they are valid
    always_ff @(posedge CLK) begin
        if (ras_we) ras_q[ras_widx] <= pc_plus_step;
    end

    assign bus.current_pc       = pc_q;
    assign bus.pc_plus_step     = pc_plus_step;
    assign bus.ras_top          = (cnt_q != '0) ? ras_q[top_idx] : RESET_PC;
    assign bus.ras_empty        = (cnt_q == '0);
    assign bus.halted           = halted_q;
    assign bus.redirect_pending = pend_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for the main behaviour and an
// 8-bit instance for address wrap.
module tb_pc_unit;
    logic CLK;
    logic nRST;
    int   n_vec;
    int   n_err;

    pc_unit_if #(.PC_W(32)) mb ();
    pc_unit_if #(.PC_W(8))  sb ();

    pc_unit #(
        .PC_W(32), .RESET_PC(32'h100), .STEP(4), .RAS_DEPTH(4)
    ) u_dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (mb)
    );

    pc_unit #(
        .PC_W(8), .RESET_PC(8'hF8), .STEP(4), .RAS_DEPTH(2)
    ) u_dut8 (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (sb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        nRST  = 1'b0;
        {mb.ihit, mb.stall, mb.halt, mb.redirect, mb.ras_push, mb.ras_pop} = '0;
        mb.redirect_pc = '0;
        {sb.ihit, sb.stall, sb.halt, sb.redirect, sb.ras_push, sb.ras_pop} = '0;
        sb.redirect_pc = '0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;

        check("rst_pc",      mb.current_pc, 32'h100);
        check("rst_step",    mb.pc_plus_step, 32'h104);
        check("rst_halted",  {31'b0, mb.halted}, 32'd0);
        check("rst_pend",    {31'b0, mb.redirect_pending}, 32'd0);
        check("rst_empty",   {31'b0, mb.ras_empty}, 32'd1);
        check("rst_top",     mb.ras_top, 32'h100);

        // 8-bit wrap: F8 -> FC -> 00
        sb.ihit = 1'b1;
        tick();
        check("w8_pc_fc",    {24'b0, sb.current_pc}, 32'hFC);
        check("w8_step_wrap", {24'b0, sb.pc_plus_step}, 32'h00);
        tick();
        check("w8_pc_00",    {24'b0, sb.current_pc}, 32'h00);
        sb.ihit = 1'b0;

        // sequential fetch, then async reset mid-cycle
        mb.ihit = 1'b1;
        tick(); check("seq_104", mb.current_pc, 32'h104);
        tick(); check("seq_108", mb.current_pc, 32'h108);
        tick(); check("seq_10c", mb.current_pc, 32'h10C);
        mb.ihit = 1'b0;
        #3 nRST = 1'b0;
        #1 check("async_rst", mb.current_pc, 32'h100);
        nRST = 1'b1;
        tick(); check("hold_noihit", mb.current_pc, 32'h100);

        // stall holds sequential fetch but not a redirect
        mb.ihit = 1'b1; mb.stall = 1'b1;
        tick(); check("stall_hold", mb.current_pc, 32'h100);
        mb.redirect = 1'b1; mb.redirect_pc = 32'h400;
        tick(); check("stall_redir", mb.current_pc, 32'h400);
        check("stall_redir_pend", {31'b0, mb.redirect_pending}, 32'd0);
        mb.stall = 1'b0;

        // redirect buffered across misses, newest wins
        mb.ihit = 1'b0; mb.redirect_pc = 32'h200;
        tick(); check("miss_pend1", {31'b0, mb.redirect_pending}, 32'd1);
        check("miss_pc1", mb.current_pc, 32'h400);
        mb.redirect_pc = 32'h300;
        tick(); check("miss_pc2", mb.current_pc, 32'h400);
        mb.redirect = 1'b0; mb.ihit = 1'b1;
        tick(); check("pend_apply", mb.current_pc, 32'h300);
        check("pend_clear", {31'b0, mb.redirect_pending}, 32'd0);

        // RAS: five pushes overflow a 4-deep stack
        mb.redirect = 1'b1; mb.redirect_pc = 32'h0;
        tick(); check("redir_0", mb.current_pc, 32'h0);
        mb.redirect = 1'b0; mb.ras_push = 1'b1;
        repeat (5) tick();
        check("push5_pc",  mb.current_pc, 32'h14);
        check("push5_top", mb.ras_top, 32'h14);
        mb.ras_push = 1'b0; mb.ras_pop = 1'b1;
        tick(); check("pop1_top", mb.ras_top, 32'h10);
        tick(); check("pop2_top", mb.ras_top, 32'hC);
        tick(); check("pop3_top", mb.ras_top, 32'h8);
        check("pop3_empty", {31'b0, mb.ras_empty}, 32'd0);
        tick(); check("pop4_empty", {31'b0, mb.ras_empty}, 32'd1);
        check("pop4_top", mb.ras_top, 32'h100);
        tick(); check("pop5_empty", {31'b0, mb.ras_empty}, 32'd1);
        check("pop5_top", mb.ras_top, 32'h100);
        mb.ras_pop = 1'b0;

        // stalled push, push+pop replace, redirect leaves RAS alone
        mb.redirect = 1'b1; mb.redirect_pc = 32'h38;
        tick(); check("redir_38", mb.current_pc, 32'h38);
        check("redir_ras", {31'b0, mb.ras_empty}, 32'd1);
        mb.redirect = 1'b0; mb.ras_push = 1'b1;
        tick(); tick();
        check("push2_pc",  mb.current_pc, 32'h40);
        check("push2_top", mb.ras_top, 32'h40);
        mb.stall = 1'b1;
        tick(); check("stall_push_top", mb.ras_top, 32'h40);
        check("stall_push_pc", mb.current_pc, 32'h40);
        mb.stall = 1'b0; mb.ras_pop = 1'b1;
        tick(); check("pushpop_top", mb.ras_top, 32'h44);
        check("pushpop_pc", mb.current_pc, 32'h44);
        mb.ras_push = 1'b0;
        tick(); check("pp_pop1_top", mb.ras_top, 32'h3C);
        check("pp_pop1_empty", {31'b0, mb.ras_empty}, 32'd0);
        tick(); check("pp_pop2_empty", {31'b0, mb.ras_empty}, 32'd1);
        mb.ras_pop = 1'b0;

        // sticky halt
        mb.redirect = 1'b1; mb.redirect_pc = 32'h20;
        tick(); check("redir_20", mb.current_pc, 32'h20);
        mb.redirect = 1'b0; mb.halt = 1'b1;
        tick(); check("halt_pc", mb.current_pc, 32'h20);
        check("halt_flag", {31'b0, mb.halted}, 32'd1);
        mb.halt = 1'b0;
        tick(); check("halted_pc", mb.current_pc, 32'h20);
        check("halted_sticky", {31'b0, mb.halted}, 32'd1);
        mb.redirect = 1'b1; mb.redirect_pc = 32'h80;
        tick(); check("halted_redir_pc", mb.current_pc, 32'h20);
        check("halted_pend", {31'b0, mb.redirect_pending}, 32'd1);
        mb.redirect = 1'b0;
        tick(); check("halted_pend_pc", mb.current_pc, 32'h20);
        check("halted_pend_keep", {31'b0, mb.redirect_pending}, 32'd1);
        mb.ihit = 1'b0;
        #2 nRST = 1'b0;
        #1 check("rst_unhalt", {31'b0, mb.halted}, 32'd0);
        check("rst_unpend", {31'b0, mb.redirect_pending}, 32'd0);
        check("rst_pc2", mb.current_pc, 32'h100);
        nRST = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
